// File: rtl/aer_layer_fifo.sv
// aer_layer_fifo
//   Buffers AER event words between two network layers. Upstream events are
//   registered once, then written into a DEPTH x DATA_W register array; when
//   the array is full and no pop frees a slot in that same cycle, the event is
//   dropped and counted. Downstream pulls one event per level-held read_req
//   through a one-hot read FSM (S_FREE -> S_REQ -> S_POP -> S_VALID).
//
// Ports
//   work_clk         in   clock, rising edge
//   rst_n            in   asynchronous active-low reset
//   aer_data_i       in   event address from upstream layer
//   spike_emit_flag  in   aer_data_i valid this cycle
//   read_req         in   downstream request for one event (level-held)
//   aer_data_o       out  last popped event, held between pops
//   aer_data_o_flag  out  one-cycle strobe: aer_data_o is new
//   fifo_empty       out  occupancy == 0
//   fifo_full        out  occupancy == DEPTH
//   fifo_level       out  occupancy, 0..DEPTH
//   overflow_sticky  out  set once any event has been dropped
//   spike_cnt        out  delivered-event count, wrapping (only with
//                         AER_FIFO_SPIKE_CNT_EN defined)
//   drop_cnt         out  dropped-event count, saturating at 0xFFFF
//
// Build option
//   AER_FIFO_SPIKE_CNT_EN : adds the spike_cnt port and its counter.

module aer_layer_fifo #(
   parameter int unsigned DATA_W = 12,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned AW     = $clog2(DEPTH)
) (
   input  logic              work_clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] aer_data_i,
   input  logic              spike_emit_flag,
   input  logic              read_req,
   output logic [DATA_W-1:0] aer_data_o,
   output logic              aer_data_o_flag,
   output logic              fifo_empty,
   output logic              fifo_full,
   output logic [AW:0]       fifo_level,
   output logic              overflow_sticky,
`ifdef AER_FIFO_SPIKE_CNT_EN
   output logic [15:0]       spike_cnt,
`endif
   output logic [15:0]       drop_cnt
);

   localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

   typedef enum logic [3:0] {
      S_FREE  = 4'b0001,
      S_REQ   = 4'b0010,
      S_POP   = 4'b0100,
      S_VALID = 4'b1000
   } rd_state_t;

   rd_state_t         state;
   logic              wr_q;
   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              pop;
   logic              push;
   logic              drop;

   assign fifo_empty = (fifo_level == '0);
   assign fifo_full  = (fifo_level == FULL_LEVEL);

   // S_POP is only entered with the FIFO non-empty, and nothing else can
   // lower the level, so a pop never underflows.
   assign pop  = (state == S_POP);
   // A pop in the same cycle frees the slot a full FIFO needs.
   assign push = wr_q && (!fifo_full || pop);
   assign drop = wr_q && fifo_full && !pop;

   // Input register stage.
   always_ff @(posedge work_clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q   <= 1'b0;
         data_q <= '0;
      end else begin
         wr_q   <= spike_emit_flag;
         data_q <= aer_data_i;
      end
   end

   // Storage array, intentionally not reset.
   always_ff @(posedge work_clk) begin
      if (push) begin
         mem[wr_ptr] <= data_q;
      end
   end

   // Pointers, occupancy and overflow accounting.
   always_ff @(posedge work_clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         fifo_level      <= '0;
         drop_cnt        <= '0;
         overflow_sticky <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + 1'b1;
            2'b01:   fifo_level <= fifo_level - 1'b1;
            default: fifo_level <= fifo_level;
         endcase
         if (drop) begin
            overflow_sticky <= 1'b1;
            if (drop_cnt != '1) drop_cnt <= drop_cnt + 16'd1;
         end
      end
   end

   // Read FSM with registered data and strobe; the strobe is high exactly
   // while the FSM sits in S_VALID.
   always_ff @(posedge work_clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= S_FREE;
         aer_data_o      <= '0;
         aer_data_o_flag <= 1'b0;
      end else begin
         aer_data_o_flag <= 1'b0;
         case (state)
            S_FREE: begin
               if (read_req) state <= S_REQ;
            end
            S_REQ: begin
               if (!read_req)       state <= S_FREE;
               else if (!fifo_empty) state <= S_POP;
            end
            S_POP: begin
               aer_data_o      <= mem[rd_ptr];
               aer_data_o_flag <= 1'b1;
               state           <= S_VALID;
            end
            S_VALID: begin
               state <= S_FREE;
            end
            default: begin
               state <= S_FREE;
            end
         endcase
      end
   end

`ifdef AER_FIFO_SPIKE_CNT_EN
   always_ff @(posedge work_clk or negedge rst_n) begin
      if (!rst_n) begin
         spike_cnt <= '0;
      end else if (aer_data_o_flag) begin
         spike_cnt <= spike_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_aer_layer_fifo.sv
// Bench for aer_layer_fifo (DATA_W=12, DEPTH=16). Expected values come from
// a queue-based model of the buffer; writes and reads are kept in separate
// phases except in the directed full-with-pop case, which is hand-timed.
module tb_aer_layer_fifo;

   localparam int DATA_W = 12;
   localparam int DEPTH  = 16;

   logic              work_clk = 1'b0;
   logic              rst_n;
   logic [DATA_W-1:0] aer_data_i;
   logic              spike_emit_flag;
   logic              read_req;
   logic [DATA_W-1:0] aer_data_o;
   logic              aer_data_o_flag;
   logic              fifo_empty;
   logic              fifo_full;
   logic [4:0]        fifo_level;
   logic              overflow_sticky;
   logic [15:0]       drop_cnt;
`ifdef AER_FIFO_SPIKE_CNT_EN
   logic [15:0]       spike_cnt;
`endif

   aer_layer_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .work_clk        (work_clk),
      .rst_n           (rst_n),
      .aer_data_i      (aer_data_i),
      .spike_emit_flag (spike_emit_flag),
      .read_req        (read_req),
      .aer_data_o      (aer_data_o),
      .aer_data_o_flag (aer_data_o_flag),
      .fifo_empty      (fifo_empty),
      .fifo_full       (fifo_full),
      .fifo_level      (fifo_level),
      .overflow_sticky (overflow_sticky),
`ifdef AER_FIFO_SPIKE_CNT_EN
      .spike_cnt       (spike_cnt),
`endif
      .drop_cnt        (drop_cnt)
   );

   always #5 work_clk = ~work_clk;

   int checks = 0;
   int errors = 0;

   // Reference model
   logic [DATA_W-1:0] mq[$];
   int unsigned       exp_drop   = 0;
   logic              exp_sticky = 1'b0;
   int unsigned       exp_spike  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge work_clk);
      #1;
   endtask

   task automatic model_reset();
      mq.delete();
      exp_drop   = 0;
      exp_sticky = 1'b0;
      exp_spike  = 0;
   endtask

   // Drive one cycle of upstream input; the model applies the accept/drop rule
   // immediately since no pop is in progress when this is used.
   task automatic drive_emit(input logic e, input logic [DATA_W-1:0] d);
      spike_emit_flag = e;
      aer_data_i      = d;
      step();
      if (e) begin
         if (mq.size() < DEPTH) mq.push_back(d);
         else begin
            exp_drop++;
            exp_sticky = 1'b1;
         end
      end
   endtask

   task automatic check_status(input string tag);
      chk({tag, "_level"}, 32'(fifo_level), mq.size());
      chk({tag, "_empty"}, 32'(fifo_empty), 32'(mq.size() == 0));
      chk({tag, "_full"},  32'(fifo_full),  32'(mq.size() == DEPTH));
      chk({tag, "_drop"},  32'(drop_cnt),   exp_drop);
      chk({tag, "_ovf"},   32'(overflow_sticky), 32'(exp_sticky));
   endtask

   // Hold read_req from an idle reader until k strobes are seen; checks data
   // order, first-strobe latency, strobe spacing and strobe width.
   task automatic read_burst(input int k);
      int got = 0;
      int budget = 0;
      int last = -1;
      logic [DATA_W-1:0] exp_d;
      if (k == 0) return;
      exp_spike += k;
      read_req = 1'b1;
      while (got < k && budget < 8 * k + 10) begin
         step();
         budget++;
         if (aer_data_o_flag) begin
            exp_d = (mq.size() != 0) ? mq.pop_front() : '0;
            chk("rd_data", 32'(aer_data_o), 32'(exp_d));
            if (last < 0) chk("rd_latency", budget, 3);
            else          chk("rd_spacing", budget - last, 4);
            last = budget;
            got++;
            if (got == k) read_req = 1'b0;
         end
      end
      read_req = 1'b0;
      chk("rd_strobes", got, k);
      step();
      chk("rd_flag_width", 32'(aer_data_o_flag), 0);
   endtask

   initial begin
      int unsigned n;
      int unsigned k;
      logic [DATA_W-1:0] d;

      rst_n           = 1'b0;
      spike_emit_flag = 1'b0;
      aer_data_i      = '0;
      read_req        = 1'b0;
      model_reset();

      // Reset state
      @(posedge work_clk);
      #3;
      check_status("rst");
      chk("rst_flag", 32'(aer_data_o_flag), 0);
      chk("rst_dout", 32'(aer_data_o), 0);
      @(negedge work_clk);
      rst_n = 1'b1;
      step();

      // Single event, level 0 -> 1 -> 0
      drive_emit(1'b1, 12'h0A5);
      spike_emit_flag = 1'b0;
      step();
      chk("single_level_up", 32'(fifo_level), 1);
      step();
      step();
      read_burst(1);
      check_status("single_after");

      // Request withdrawn on empty FIFO: no strobe, output held
      read_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("withdraw_flag", 32'(aer_data_o_flag), 0);
      end
      read_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("withdraw_flag_low", 32'(aer_data_o_flag), 0);
      end
      chk("withdraw_dout", 32'(aer_data_o), 12'h0A5);

      // Fill past capacity: 20 back-to-back events
      for (int i = 0; i < 20; i++) drive_emit(1'b1, DATA_W'(i));
      spike_emit_flag = 1'b0;
      step();
      step();
      chk("fill_drop4", 32'(drop_cnt), 4);
      check_status("fill");

      // Full FIFO, write lands in the pop cycle: accepted, level stays 16
      read_req = 1'b1;
      step();
      spike_emit_flag = 1'b1;
      aer_data_i      = 12'h3C3;
      step();
      spike_emit_flag = 1'b0;
      step();
      read_req = 1'b0;
      chk("simul_flag", 32'(aer_data_o_flag), 1);
      chk("simul_data", 32'(aer_data_o), 0);
      exp_spike++;
      void'(mq.pop_front());
      mq.push_back(12'h3C3);
      check_status("simul");
      step();
      read_burst(16);
      check_status("fill_drained");

      // Reset mid-operation with an event in flight
      for (int i = 0; i < 5; i++) drive_emit(1'b1, DATA_W'(12'h100 + i));
      spike_emit_flag = 1'b1;
      aer_data_i      = 12'h155;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_status("midrst");
      chk("midrst_flag", 32'(aer_data_o_flag), 0);
      chk("midrst_dout", 32'(aer_data_o), 0);
`ifdef AER_FIFO_SPIKE_CNT_EN
      chk("midrst_spike", 32'(spike_cnt), 0);
`endif
      spike_emit_flag = 1'b0;
      step();
      @(negedge work_clk);
      rst_n           = 1'b1;
      spike_emit_flag = 1'b1;
      aer_data_i      = 12'h2AA;
      step();
      spike_emit_flag = 1'b0;
      mq.push_back(12'h2AA);
      step();
      check_status("post_rst_write");
      step();
      read_burst(1);

      // Pointer wrap: 40 write/read pairs
      for (int i = 0; i < 40; i++) begin
         drive_emit(1'b1, DATA_W'($urandom_range(0, 4095)));
         spike_emit_flag = 1'b0;
         step();
         step();
         read_burst(1);
      end
      check_status("wrap");

      // Randomized write bursts and read drains
      for (int r = 0; r < 12; r++) begin
         n = $urandom_range(0, 22);
         for (int unsigned i = 0; i < n; i++) begin
            d = DATA_W'($urandom_range(0, 4095));
            drive_emit(1'($urandom_range(0, 1)), d);
         end
         spike_emit_flag = 1'b0;
         step();
         step();
         check_status("rnd_wr");
         k = $urandom_range(0, mq.size());
         read_burst(int'(k));
         check_status("rnd_rd");
      end

`ifdef AER_FIFO_SPIKE_CNT_EN
      chk("spike_cnt", 32'(spike_cnt), exp_spike);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/aer_layer_fifo.md
AER_LAYER_FIFO -- requirements
Module: aer_layer_fifo

Interface
REQ-001 Parameter DATA_W, default 12: AER event word width in bits.
REQ-002 Parameter DEPTH, default 16: FIFO capacity in words; a power of two, 4..1024.
REQ-003 Parameter AW, default log2(DEPTH): pointer width; fifo_level is AW+1 bits.
REQ-004 work_clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 aer_data_i  in  DATA_W  event address from the upstream layer.
REQ-007 spike_emit_flag  in  1  aer_data_i valid this cycle.
REQ-008 read_req  in  1  downstream request for one event, level-held.
REQ-009 aer_data_o  out  DATA_W  last popped event.
REQ-010 aer_data_o_flag  out  1  one-cycle strobe: aer_data_o is new.
REQ-011 fifo_empty / fifo_full  out  1 each  occupancy 0 / DEPTH.
REQ-012 fifo_level  out  AW+1  current occupancy, 0..DEPTH.
REQ-013 overflow_sticky  out  1  set when any event has been dropped.
REQ-014 drop_cnt  out  16  number of dropped events, saturating.
REQ-015 spike_cnt  out  16  delivered-event count (present only under REQ-034).

Function
REQ-016 Write stage SHALL register aer_data_i and spike_emit_flag, giving wr_q/data_q one cycle later.
REQ-017 Storage SHALL be an internal DEPTH x DATA_W register array with no vendor IP, and with wrapping AW-bit read/write pointers.
REQ-018 When wr_q=1 and the FIFO is not full, or is full with a pop in the same cycle, the block SHALL write data_q and advance the write pointer.
REQ-019 When wr_q=1, the FIFO is full and no pop occurs that cycle, the block SHALL drop the event, increment drop_cnt (hold at 0xFFFF), and set overflow_sticky.
REQ-020 Read FSM states: S_FREE, S_REQ, S_POP, S_VALID; state is registered and the encoding is one-hot.
REQ-021 S_FREE: go to S_REQ if read_req=1, else stay.
REQ-022 S_REQ: go to S_POP if read_req=1 and !fifo_empty; go to S_FREE if read_req=0; else stay.
REQ-023 S_POP: pop exactly one word, load it into aer_data_o at the end of this cycle, advance the read pointer, then go to S_VALID unconditionally.
REQ-024 S_VALID: aer_data_o_flag=1 for exactly this cycle, then go to S_FREE; aer_data_o_flag=0 in every other state.
REQ-025 Latency: a read_req sampled high in S_REQ with the FIFO non-empty at edge N SHALL produce aer_data_o_flag high in cycle N+2; the minimum spacing between strobes is 4 cycles.
REQ-026 aer_data_o SHALL hold its value between pops.
REQ-027 fifo_level SHALL change by +1 on a write only, -1 on a pop only, and 0 on a simultaneous write and pop or on neither.
REQ-028 fifo_empty SHALL equal (fifo_level==0) and fifo_full SHALL equal (fifo_level==DEPTH); both are derived from registered state.
REQ-029 A simultaneous write and pop on an empty FIFO SHALL NOT occur, since a pop requires !fifo_empty one cycle earlier; the written word becomes readable on the next request.
REQ-030 Ordering SHALL be strict FIFO across pointer wrap-around.

Reset
REQ-031 When rst_n=0, the block SHALL immediately clear the pointers, fifo_level, wr_q, data_q, aer_data_o, aer_data_o_flag, drop_cnt, spike_cnt and overflow_sticky, and set the FSM to S_FREE. After reset fifo_empty=1 and fifo_full=0. Array contents are not reset.
REQ-032 Reset asserted mid-transfer SHALL discard all stored events; the in-flight data_q is lost and no strobe is produced.
REQ-033 The first write SHALL be accepted from the first rising edge after rst_n deasserts.

Configuration
REQ-034 Macro AER_FIFO_SPIKE_CNT_EN. When defined, the block SHALL include spike_cnt, which increments on each cycle with aer_data_o_flag=1 and wraps at 0xFFFF to 0. When undefined, the block SHALL omit the spike_cnt port and its logic; all other behaviour is identical.

Verification
REQ-035 Single event: write 0x0A5 at cycle 0, read_req held from cycle 5 -> aer_data_o=0x0A5 with flag high for 1 cycle; fifo_level goes 0->1->0.
REQ-036 Fill with DEPTH=16: write 20 events 0x000..0x013 back-to-back with no reads -> fifo_full=1, fifo_level=16, drop_cnt=4, overflow_sticky=1; reads return 0x000..0x00F in order.
REQ-037 Wrap: do 40 interleaved write/read pairs with DEPTH=16 -> all 40 values are returned in order and drop_cnt=0.
REQ-038 Full with simultaneous write and pop: FIFO full, a pop occurs in the same cycle wr_q=1 -> the event is accepted, fifo_level stays 16, and drop_cnt is unchanged.
REQ-039 Request withdrawn: FIFO empty, read_req high 3 cycles then low -> FSM returns to S_FREE, no strobe, and aer_data_o is unchanged.
REQ-040 Reset mid-operation: 5 events stored, rst_n pulsed low -> outputs are at reset values, fifo_empty=1, and spike_cnt=0 (with the macro defined).
